c_reg_fd_v5_0: RTL and testbench
================================

Name: c_reg_fd_v5_0

Overview:
- Generic C_WIDTH-bit D flip-flop register with optional clock enable, async set/init and sync clear/set/init.
- Base pipeline element for mux, adder and counter cores; cores chain several instances to build latency stages.
- Controls not enabled by their C_HAS_* parameter are ignored.

Parameters:
- C_AINIT_VAL, 0, C_WIDTH-bit value loaded by AINIT.
- C_ENABLE_RLOCS, 1, placement hint only; no functional effect.
- C_HAS_AINIT, 0, 1 = AINIT input active.
- C_HAS_ASET, 0, 1 = ASET input active.
- C_HAS_CE, 0, 1 = CE input active; 0 = register always enabled.
- C_HAS_SCLR, 0, 1 = SCLR input active.
- C_HAS_SINIT, 0, 1 = SINIT input active.
- C_HAS_SSET, 0, 1 = SSET input active.
- C_SINIT_VAL, 0, C_WIDTH-bit value loaded by SINIT.
- C_SYNC_ENABLE, 0, 0 = sync controls override CE; 1 = sync controls act only when CE=1.
- C_SYNC_PRIORITY, 1, 1 = SCLR beats SSET; 0 = SSET beats SCLR.
- C_WIDTH, 16, data width (>=1).

Ports:
- CLK  in  1  rising-edge clock.
- ACLR_N  in  1  async clear, active-low, always functional.
- D  in  C_WIDTH  data in.
- CE  in  1  clock enable, active-high.
- ASET  in  1  async set to all-ones, active-high.
- AINIT  in  1  async load C_AINIT_VAL, active-high.
- SCLR  in  1  sync clear to 0.
- SSET  in  1  sync set to all-ones.
- SINIT  in  1  sync load C_SINIT_VAL.
- Q  out  C_WIDTH  registered output.

Behaviour:
- Async priority, evaluated continuously:
  - ACLR_N=0: Q=0.
  - else ASET=1 (if enabled): Q=all-ones.
  - else AINIT=1 (if enabled): Q=C_AINIT_VAL.
  - Takes effect immediately, without waiting for a clock edge; held while asserted.
- Reset value of Q is 0. After reset, Q holds until the first qualifying rising CLK edge.
- Effective enable: en = CE if C_HAS_CE=1, else 1.
- Rising CLK edge with no async control active:
  - Sync controls are gated by en only when C_SYNC_ENABLE=1.
  - SINIT (highest sync priority): Q<=C_SINIT_VAL.
  - else SCLR and SSET both active: result follows C_SYNC_PRIORITY (1 gives 0, 0 gives all-ones).
  - else SCLR: Q<=0; else SSET: Q<=all-ones.
  - else en=1: Q<=D; otherwise hold.
- Latency D->Q is one CLK cycle; there is no combinational path.
- Async release mid-cycle: Q keeps the async value until the next edge.
- Async assertion coincident with a clock edge: the async control wins.
- C_AINIT_VAL and C_SINIT_VAL are truncated or zero-extended to C_WIDTH.
- Disabled inputs may be left unconnected (tie 0).

Optional Feature:
- Macro C_REG_FD_XPROP_EN.
- Defined: at a rising CLK edge, if any enabled sync control, or CE when C_HAS_CE=1, is X/Z, Q becomes all-X. Any enabled async control at X/Z also forces Q to all-X. Simulation-only; the logic is excluded from synthesis.
- Undefined: X/Z controls are treated as inactive per the normal if/else priority, and no X is injected.

Test Plan:
- C_WIDTH=8, defaults: ACLR_N=0 -> Q=0x00. Release, D=0xA5, one edge -> Q=0xA5. D=0x3C -> Q=0x3C next edge.
- C_HAS_CE=1: CE=0, D=0xFF -> Q holds 0x3C. CE=1 -> Q=0xFF next edge.
- C_HAS_SCLR=1, C_HAS_SSET=1, C_HAS_CE=1, C_SYNC_ENABLE=0, CE=0, SCLR=SSET=1:
  - C_SYNC_PRIORITY=1 -> Q=0x00.
  - C_SYNC_PRIORITY=0 -> Q=0xFF.
  - With C_SYNC_ENABLE=1 and CE=0 -> Q holds.
- C_HAS_SINIT=1, C_SINIT_VAL=0x5A, SINIT=SCLR=1 -> Q=0x5A next edge.
- C_HAS_ASET=1, C_HAS_AINIT=1, C_AINIT_VAL=0x81:
  - AINIT=1 mid-cycle -> Q=0x81 immediately.
  - ASET=1 as well -> Q=0xFF.
  - ACLR_N=0 as well -> Q=0x00.
  - Release all, D=0x12 -> Q=0x12 next edge.
- C_REG_FD_XPROP_EN defined, C_HAS_CE=1, CE=X at edge -> Q=0xXX. Macro undefined -> Q holds.

Source files
------------

// File: rtl/c_reg_fd_v5_0_if.sv
// Data/control bundle for c_reg_fd_v5_0. The master drives data and controls;
// the slave (the register) drives q.
interface c_reg_fd_v5_0_if #(
   parameter int unsigned C_WIDTH = 16
);
   logic [C_WIDTH-1:0] d;
   logic               ce;
   logic               aset;
   logic               ainit;
   logic               sclr;
   logic               sset;
   logic               sinit;
   logic [C_WIDTH-1:0] q;

   modport master (
      output d, ce, aset, ainit, sclr, sset, sinit,
      input  q
   );

   modport slave (
      input  d, ce, aset, ainit, sclr, sset, sinit,
      output q
   );
endinterface

// File: rtl/c_reg_fd_v5_0.sv
// Generic C_WIDTH-bit register with optional clock enable, async set/init and
// sync clear/set/init. Controls whose C_HAS_* parameter is 0 are ignored.
// Optional macro C_REG_FD_XPROP_EN: simulation-only X propagation from X/Z
// controls into q (absent from synthesis builds).
module c_reg_fd_v5_0 #(
   parameter int unsigned  C_WIDTH         = 16,
   parameter logic [C_WIDTH-1:0] C_AINIT_VAL = '0,
   parameter logic [C_WIDTH-1:0] C_SINIT_VAL = '0,
   parameter int unsigned  C_ENABLE_RLOCS  = 1,
   parameter int unsigned  C_HAS_AINIT     = 0,
   parameter int unsigned  C_HAS_ASET      = 0,
   parameter int unsigned  C_HAS_CE        = 0,
   parameter int unsigned  C_HAS_SCLR      = 0,
   parameter int unsigned  C_HAS_SINIT     = 0,
   parameter int unsigned  C_HAS_SSET      = 0,
   parameter int unsigned  C_SYNC_ENABLE   = 0,
   parameter int unsigned  C_SYNC_PRIORITY = 1
) (
   input  logic            clk_i,
   input  logic            aclr_ni,
   c_reg_fd_v5_0_if.slave  bus
);

   // Placement hint only; reject nonsense values at elaboration.
   if (C_ENABLE_RLOCS > 1) begin : g_rlocs_chk
      $error("C_ENABLE_RLOCS must be 0 or 1");
   end
   if ($bits(bus.q) != C_WIDTH) begin : g_width_chk
      $error("interface width does not match C_WIDTH");
   end

   localparam logic [C_WIDTH-1:0] Ones = '1;

   logic [C_WIDTH-1:0] q_q, q_d;
   logic en, sync_en, aset_act, ainit_act, sclr_act, sset_act, sinit_act;

   // Tie off controls that are not enabled by their C_HAS_* parameter.
   assign en        = (C_HAS_CE    != 0) ? bus.ce    : 1'b1;
   assign aset_act  = (C_HAS_ASET  != 0) ? bus.aset  : 1'b0;
   assign ainit_act = (C_HAS_AINIT != 0) ? bus.ainit : 1'b0;
   assign sclr_act  = (C_HAS_SCLR  != 0) ? bus.sclr  : 1'b0;
   assign sset_act  = (C_HAS_SSET  != 0) ? bus.sset  : 1'b0;
   assign sinit_act = (C_HAS_SINIT != 0) ? bus.sinit : 1'b0;
   // Sync controls override CE unless C_SYNC_ENABLE asks for gating.
   assign sync_en   = (C_SYNC_ENABLE != 0) ? en : 1'b1;

`ifdef C_REG_FD_XPROP_EN
   logic async_x, sync_x;
   assign async_x = $isunknown(aclr_ni) | $isunknown(aset_act) | $isunknown(ainit_act);
   assign sync_x  = $isunknown(en) | $isunknown(sclr_act) | $isunknown(sset_act)
                  | $isunknown(sinit_act);
`endif

   // Next-state: sync controls in priority order, then enabled load, else hold.
   always_comb begin
      q_d = q_q;
      if (sync_en && sinit_act) begin
         q_d = C_SINIT_VAL;
      end else if (sync_en && sclr_act && sset_act) begin
         q_d = (C_SYNC_PRIORITY != 0) ? '0 : Ones;
      end else if (sync_en && sclr_act) begin
         q_d = '0;
      end else if (sync_en && sset_act) begin
         q_d = Ones;
      end else if (en) begin
         q_d = bus.d;
      end
   end

   // State register: async clear > async set > async init, else clocked update.
   always_ff @(posedge clk_i or negedge aclr_ni or posedge aset_act or posedge ainit_act) begin
      if (!aclr_ni) begin
         q_q <= '0;
`ifdef C_REG_FD_XPROP_EN
      end else if (async_x) begin
         q_q <= 'x;
`endif
      end else if (aset_act) begin
         q_q <= Ones;
      end else if (ainit_act) begin
         q_q <= C_AINIT_VAL;
`ifdef C_REG_FD_XPROP_EN
      end else if (sync_x) begin
         q_q <= 'x;
`endif
      end else begin
         q_q <= q_d;
      end
   end

   assign bus.q = q_q;

endmodule

// File: tb/tb_c_reg_fd_v5_0.sv
// Directed bench for c_reg_fd_v5_0: several parameterisations side by side.
module tb_c_reg_fd_v5_0;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   c_reg_fd_v5_0_if #(.C_WIDTH(8)) if_e ();  // all defaults
   c_reg_fd_v5_0_if #(.C_WIDTH(8)) if_a ();  // CE, SCLR/SSET/SINIT, prio 1
   c_reg_fd_v5_0_if #(.C_WIDTH(8)) if_b ();  // CE, SCLR/SSET, prio 0
   c_reg_fd_v5_0_if #(.C_WIDTH(8)) if_c ();  // CE, SCLR/SSET, sync enable
   c_reg_fd_v5_0_if #(.C_WIDTH(8)) if_d ();  // ASET/AINIT

   c_reg_fd_v5_0 #(.C_WIDTH(8)) u_e (.clk_i(clk), .aclr_ni(rst_n), .bus(if_e));

   c_reg_fd_v5_0 #(.C_WIDTH(8), .C_HAS_CE(1), .C_HAS_SCLR(1), .C_HAS_SSET(1),
      .C_HAS_SINIT(1), .C_SINIT_VAL(8'h5A), .C_SYNC_ENABLE(0), .C_SYNC_PRIORITY(1))
      u_a (.clk_i(clk), .aclr_ni(rst_n), .bus(if_a));

   c_reg_fd_v5_0 #(.C_WIDTH(8), .C_HAS_CE(1), .C_HAS_SCLR(1), .C_HAS_SSET(1),
      .C_SYNC_ENABLE(0), .C_SYNC_PRIORITY(0))
      u_b (.clk_i(clk), .aclr_ni(rst_n), .bus(if_b));

   c_reg_fd_v5_0 #(.C_WIDTH(8), .C_HAS_CE(1), .C_HAS_SCLR(1), .C_HAS_SSET(1),
      .C_SYNC_ENABLE(1), .C_SYNC_PRIORITY(1))
      u_c (.clk_i(clk), .aclr_ni(rst_n), .bus(if_c));

   c_reg_fd_v5_0 #(.C_WIDTH(8), .C_HAS_ASET(1), .C_HAS_AINIT(1), .C_AINIT_VAL(8'h81))
      u_d (.clk_i(clk), .aclr_ni(rst_n), .bus(if_d));

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive the same controls onto the three sync-capable instances.
   task automatic drive_abc(input logic [7:0] d, input logic ce, input logic sclr,
                            input logic sset, input logic sinit);
      if_a.d = d; if_a.ce = ce; if_a.sclr = sclr; if_a.sset = sset; if_a.sinit = sinit;
      if_b.d = d; if_b.ce = ce; if_b.sclr = sclr; if_b.sset = sset; if_b.sinit = sinit;
      if_c.d = d; if_c.ce = ce; if_c.sclr = sclr; if_c.sset = sset; if_c.sinit = sinit;
   endtask

   task automatic test_reset();
      if_e.d = 8'hFF; if_e.ce = 1'b0; if_e.aset = 1'b0; if_e.ainit = 1'b0;
      if_e.sclr = 1'b0; if_e.sset = 1'b0; if_e.sinit = 1'b0;
      if_d.d = 8'hFF; if_d.ce = 1'b0; if_d.aset = 1'b0; if_d.ainit = 1'b0;
      if_d.sclr = 1'b0; if_d.sset = 1'b0; if_d.sinit = 1'b0;
      if_a.aset = 1'b0; if_a.ainit = 1'b0;
      if_b.aset = 1'b0; if_b.ainit = 1'b0;
      if_c.aset = 1'b0; if_c.ainit = 1'b0;
      drive_abc(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if (if_e.q !== 8'h00) begin errors++; $display("FAIL reset_e: got %h expected 00", if_e.q); end
      checks++;
      if (if_a.q !== 8'h00) begin errors++; $display("FAIL reset_a: got %h expected 00", if_a.q); end
      checks++;
      if (if_d.q !== 8'h00) begin errors++; $display("FAIL reset_d: got %h expected 00", if_d.q); end
      #2 rst_n = 1'b1;  // release mid-cycle
      #1;
      checks++;
      if (if_e.q !== 8'h00) begin errors++; $display("FAIL reset_hold: got %h expected 00", if_e.q); end
   endtask

   task automatic test_basic();
      @(posedge clk); #1;
      if_e.d = 8'hA5;
      step();
      checks++;
      if (if_e.q !== 8'hA5) begin errors++; $display("FAIL basic_a5: got %h expected a5", if_e.q); end
      if_e.d = 8'h3C;
      step();
      checks++;
      if (if_e.q !== 8'h3C) begin errors++; $display("FAIL basic_3c: got %h expected 3c", if_e.q); end
   endtask

   task automatic test_ce();
      drive_abc(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (if_a.q !== 8'h3C) begin errors++; $display("FAIL ce_load: got %h expected 3c", if_a.q); end
      drive_abc(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (if_a.q !== 8'h3C) begin errors++; $display("FAIL ce_hold: got %h expected 3c", if_a.q); end
      drive_abc(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (if_a.q !== 8'hFF) begin errors++; $display("FAIL ce_en: got %h expected ff", if_a.q); end
   endtask

   task automatic test_sync_priority();
      drive_abc(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive_abc(8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      checks++;
      if (if_a.q !== 8'h00) begin errors++; $display("FAIL prio1_clr: got %h expected 00", if_a.q); end
      checks++;
      if (if_b.q !== 8'hFF) begin errors++; $display("FAIL prio0_set: got %h expected ff", if_b.q); end
      checks++;
      if (if_c.q !== 8'h3C) begin errors++; $display("FAIL syncen_hold: got %h expected 3c", if_c.q); end
      drive_abc(8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      checks++;
      if (if_c.q !== 8'h00) begin errors++; $display("FAIL syncen_clr: got %h expected 00", if_c.q); end
      // Single sync controls with CE low.
      drive_abc(8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      checks++;
      if (if_a.q !== 8'hFF) begin errors++; $display("FAIL sset_only: got %h expected ff", if_a.q); end
      drive_abc(8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      checks++;
      if (if_b.q !== 8'h00) begin errors++; $display("FAIL sclr_only: got %h expected 00", if_b.q); end
   endtask

   task automatic test_sinit();
      drive_abc(8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      checks++;
      if (if_a.q !== 8'h5A) begin errors++; $display("FAIL sinit: got %h expected 5a", if_a.q); end
      // SINIT is disabled on instance B: SCLR alone applies.
      checks++;
      if (if_b.q !== 8'h00) begin errors++; $display("FAIL sinit_dis: got %h expected 00", if_b.q); end
      drive_abc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_async();
      if_d.d = 8'h00;
      step();
      if_d.d = 8'h33;
      #1 if_d.ainit = 1'b1;
      #1;
      checks++;
      if (if_d.q !== 8'h81) begin errors++; $display("FAIL ainit: got %h expected 81", if_d.q); end
      if_d.aset = 1'b1;
      #1;
      checks++;
      if (if_d.q !== 8'hFF) begin errors++; $display("FAIL aset: got %h expected ff", if_d.q); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (if_d.q !== 8'h00) begin errors++; $display("FAIL aclr: got %h expected 00", if_d.q); end
      rst_n = 1'b1; if_d.aset = 1'b0; if_d.ainit = 1'b0;
      #1;
      checks++;
      if (if_d.q !== 8'h00) begin errors++; $display("FAIL async_release: got %h expected 00", if_d.q); end
      if_d.d = 8'h12;
      step();
      checks++;
      if (if_d.q !== 8'h12) begin errors++; $display("FAIL post_async: got %h expected 12", if_d.q); end
      // Async init asserted right at a clock edge beats the clocked load.
      if_d.d = 8'h44;
      @(posedge clk);
      if_d.ainit = 1'b1;
      #1;
      checks++;
      if (if_d.q !== 8'h81) begin errors++; $display("FAIL ainit_edge: got %h expected 81", if_d.q); end
      if_d.ainit = 1'b0;
      step();
      checks++;
      if (if_d.q !== 8'h44) begin errors++; $display("FAIL ainit_edge_rel: got %h expected 44", if_d.q); end
   endtask

   task automatic test_xprop();
      drive_abc(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      if_a.d = 8'hFF;
      if_a.ce = 1'bx;
      step();
      checks++;
`ifdef C_REG_FD_XPROP_EN
      if (if_a.q !== 8'hxx) begin errors++; $display("FAIL xprop_ce: got %h expected xx", if_a.q); end
`else
      if (if_a.q !== 8'h3C) begin errors++; $display("FAIL xprop_ce: got %h expected 3c", if_a.q); end
`endif
      if_a.ce = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ce();
      test_sync_priority();
      test_sinit();
      test_async();
      test_xprop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
